// File: rtl/uart_tx_port.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_port
// Description : Memory-mapped 8N1 UART transmitter with a TX FIFO and a
//               polled STATUS register on the uart_* bus port.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_port #(
    parameter int DEPTH        = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        uart_valid,
    input  logic        uart_instr,
    input  logic [31:0] uart_addr,
    input  logic [31:0] uart_wdata,
    input  logic [3:0]  uart_wstrb,
    output logic [31:0] uart_rdata,
    output logic        uart_ready,
    output logic        uart_tx
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  COUNT_FULL  = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ready_q, ready_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [7:0]         mem_q [DEPTH];

    logic        full;
    logic        empty;
    logic        busy;
    logic        pop;
    logic        push;
    logic        req;
    logic        push_req;
    logic        baud_done;
    logic [31:0] status_word;
    logic        unused_bits;

    assign full        = (count_q == COUNT_FULL);
    assign empty       = (count_q == '0);
    assign busy        = (state_q != ST_IDLE);
    assign baud_done   = (baud_q == '0);
    assign status_word = {16'h0000, 8'(count_q), 5'b00000, busy, empty, full};
    assign unused_bits = ^{uart_addr[31:3], uart_addr[1:0], uart_wdata[31:8]};

    assign uart_tx    = tx_q;
    assign uart_ready = ready_q;
    assign uart_rdata = rdata_q;

    // Bus side: the ready pulse masks the still-held request so it is not taken twice.
    always_comb begin
        ready_d  = 1'b0;
        rdata_d  = 32'h0000_0000;
        req      = uart_valid && !ready_q;
        push_req = req && !uart_instr && !uart_addr[2] && uart_wstrb[0];
        push     = push_req && (!full || pop);
        if (req) begin
            if (uart_instr) begin
                ready_d = 1'b1;
            end else if (!uart_addr[2]) begin
                ready_d = uart_wstrb[0] ? push : 1'b1;
            end else begin
                ready_d = 1'b1;
                if (uart_wstrb == 4'b0000) begin
                    rdata_d = status_word;
                end
            end
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Serializer: every state holds the line for CLKS_PER_BIT cycles.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    tx_d    = 1'b0;
                    baud_d  = BAUD_RELOAD;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (baud_done) begin
                    state_d   = ST_DATA;
                    tx_d      = shift_q[0];
                    bit_idx_d = 3'd0;
                    baud_d    = BAUD_RELOAD;
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_done) begin
                    baud_d = BAUD_RELOAD;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_done) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        tx_d    = 1'b0;
                        baud_d  = BAUD_RELOAD;
                        state_d = ST_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q - BAUD_W'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ready_q   <= 1'b0;
            rdata_q   <= 32'h0000_0000;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
        end
    end

    // Storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= uart_wdata[7:0];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_port
// Description : Self-checking bench for uart_tx_port with a frame decoder
//               scoreboard (CLKS_PER_BIT=4, DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_port;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic        clock;
    logic        reset;
    logic        uart_valid;
    logic        uart_instr;
    logic [31:0] uart_addr;
    logic [31:0] uart_wdata;
    logic [3:0]  uart_wstrb;
    logic [31:0] uart_rdata;
    logic        uart_ready;
    logic        uart_tx;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] exp_q [$];
    int         frame_count = 0;
    int         frame_start [64];
    bit         mon_active = 0;
    bit         mon_bad;
    bit         mon_noexp;
    int         mon_k;
    logic [7:0] mon_exp;
    logic [7:0] mon_byte;

    uart_tx_port #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
        .clock      (clock),
        .reset      (reset),
        .uart_valid (uart_valid),
        .uart_instr (uart_instr),
        .uart_addr  (uart_addr),
        .uart_wdata (uart_wdata),
        .uart_wstrb (uart_wstrb),
        .uart_rdata (uart_rdata),
        .uart_ready (uart_ready),
        .uart_tx    (uart_tx)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Frame decoder: checks every cycle of each frame against the scoreboard head.
    always @(negedge clock) begin
        if (reset) begin
            mon_active = 0;
            exp_q.delete();
        end else begin
            if (!mon_active && uart_tx === 1'b0) begin
                mon_active = 1;
                mon_k      = 0;
                mon_bad    = 0;
                mon_byte   = 8'h00;
                if (frame_count < 64) frame_start[frame_count] = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: start bit at cycle %0d, required none", cyc);
                    mon_noexp = 1;
                    mon_exp   = 8'h00;
                end else begin
                    mon_noexp = 0;
                    mon_exp   = exp_q[0];
                end
            end
            if (mon_active) begin
                logic lvl;
                int   b;
                b = mon_k / CPB;
                if (b == 0)      lvl = 1'b0;
                else if (b == 9) lvl = 1'b1;
                else             lvl = mon_exp[b-1];
                if (uart_tx !== lvl) mon_bad = 1;
                if ((mon_k % CPB) == 2 && b >= 1 && b <= 8) mon_byte[b-1] = uart_tx;
                mon_k++;
                if (mon_k == 10 * CPB) begin
                    checks++;
                    if (mon_bad) begin
                        errors++;
                        $display("FAIL frame_waveform: frame %0d deviates from 8N1 of 0x%02h", frame_count, mon_exp);
                    end
                    checks++;
                    if (mon_byte !== mon_exp) begin
                        errors++;
                        $display("FAIL frame_byte: got 0x%02h, required 0x%02h", mon_byte, mon_exp);
                    end
                    if (!mon_noexp) void'(exp_q.pop_front());
                    frame_count++;
                    mon_active = 0;
                end
            end
        end
    end

    task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input logic instr,
                            output logic [31:0] rdata, output int nwait, output int rdy_cyc,
                            output logic rdy_after, output logic [31:0] rdata_after);
        @(posedge clock);
        #1;
        uart_valid = 1'b1;
        uart_addr  = addr;
        uart_wdata = wdata;
        uart_wstrb = wstrb;
        uart_instr = instr;
        nwait      = 0;
        do begin
            @(negedge clock);
            nwait++;
        end while (uart_ready !== 1'b1 && nwait < 600);
        if (uart_ready !== 1'b1) nwait = -1;
        rdata      = uart_rdata;
        rdy_cyc    = cyc;
        uart_valid = 1'b0;
        uart_wstrb = 4'h0;
        uart_instr = 1'b0;
        @(negedge clock);
        rdy_after   = uart_ready;
        rdata_after = uart_rdata;
    endtask

    task automatic wait_frames(input int target, input int budget);
        for (int i = 0; i < budget && frame_count < target; i++) @(negedge clock);
    endtask

    task automatic test_reset;
        logic [31:0] rd, rd2;
        int n, rc, fc0;
        logic ra;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checks++; if (uart_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b, required 0", uart_ready); end
        checks++; if (uart_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got 0x%08h, required 0x00000000", uart_rdata); end
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b, required 1", uart_tx); end
        fc0 = frame_count;
        bus_xfer(32'h4, 32'h0, 4'h0, 1'b0, rd, n, rc, ra, rd2);
        checks++; if (n !== 2) begin errors++; $display("FAIL status_latency: got %0d, required 2", n); end
        checks++; if (rd !== 32'h0000_0002) begin errors++; $display("FAIL status_after_reset: got 0x%08h, required 0x00000002", rd); end
        checks++; if (ra !== 1'b0) begin errors++; $display("FAIL ready_one_cycle: got %b, required 0", ra); end
        checks++; if (rd2 !== 32'h0) begin errors++; $display("FAIL rdata_idle_zero: got 0x%08h, required 0x00000000", rd2); end
        repeat (20) @(negedge clock);
        checks++; if (frame_count !== fc0 || uart_tx !== 1'b1) begin errors++; $display("FAIL idle_line: frames %0d tx %b, required %0d and 1", frame_count, uart_tx, fc0); end
    endtask

    task automatic test_single_byte;
        logic [31:0] rd, rd2;
        int n, rc, fc0;
        logic ra;
        fc0 = frame_count;
        exp_q.push_back(8'hA5);
        bus_xfer(32'h0, 32'hFFFF_FFA5, 4'h1, 1'b0, rd, n, rc, ra, rd2);
        checks++; if (n !== 2) begin errors++; $display("FAIL write_latency: got %0d, required 2", n); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL write_rdata: got 0x%08h, required 0x00000000", rd); end
        wait_frames(fc0 + 1, 100);
        checks++; if (frame_count !== fc0 + 1) begin errors++; $display("FAIL single_frame_count: got %0d, required %0d", frame_count, fc0 + 1); end
        checks++; if (frame_start[fc0] - rc !== 1) begin errors++; $display("FAIL start_bit_timing: got %0d, required 1", frame_start[fc0] - rc); end
        @(negedge clock);
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL line_after_frame: got %b, required 1", uart_tx); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd, rd2;
        int n, rc, fc0;
        logic ra;
        fc0 = frame_count;
        for (int i = 1; i <= 6; i++) begin
            exp_q.push_back(8'(i));
            bus_xfer(32'h0, 32'(i), 4'h1, 1'b0, rd, n, rc, ra, rd2);
            if (i < 6) begin
                checks++; if (n !== 2) begin errors++; $display("FAIL b2b_latency_%0d: got %0d, required 2", i, n); end
            end
        end
        checks++; if (n <= 2) begin errors++; $display("FAIL full_stall: latency %0d, required > 2", n); end
        wait_frames(fc0 + 6, 400);
        checks++; if (frame_count !== fc0 + 6) begin errors++; $display("FAIL b2b_frame_count: got %0d, required %0d", frame_count, fc0 + 6); end
        checks++; if (rc !== frame_start[fc0 + 1]) begin errors++; $display("FAIL stall_release: ready at %0d, required %0d", rc, frame_start[fc0 + 1]); end
        for (int i = 1; i < 6; i++) begin
            checks++;
            if (frame_start[fc0 + i] - frame_start[fc0 + i - 1] !== 10 * CPB) begin
                errors++;
                $display("FAIL b2b_gap_%0d: got %0d, required %0d", i, frame_start[fc0 + i] - frame_start[fc0 + i - 1], 10 * CPB);
            end
        end
    endtask

    task automatic test_fill_status;
        logic [31:0] rd, rd2;
        int n, rc, fc0;
        logic ra;
        fc0 = frame_count;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(8'h11 * 8'(i + 1));
            bus_xfer(32'h0, 32'h11 * 32'(i + 1), 4'h1, 1'b0, rd, n, rc, ra, rd2);
        end
        bus_xfer(32'h4, 32'h0, 4'h0, 1'b0, rd, n, rc, ra, rd2);
        checks++; if (rd !== 32'h0000_0405) begin errors++; $display("FAIL status_full: got 0x%08h, required 0x00000405", rd); end
        repeat (260) @(negedge clock);
        checks++; if (frame_count !== fc0 + 5) begin errors++; $display("FAIL drain_frames: got %0d, required %0d", frame_count, fc0 + 5); end
        bus_xfer(32'h4, 32'h0, 4'h0, 1'b0, rd, n, rc, ra, rd2);
        checks++; if (rd !== 32'h0000_0002) begin errors++; $display("FAIL status_drained: got 0x%08h, required 0x00000002", rd); end
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL drained_line: got %b, required 1", uart_tx); end
    endtask

    task automatic test_no_push_cases;
        logic [31:0] rd, rd2;
        int n, rc, fc0;
        logic ra;
        fc0 = frame_count;
        bus_xfer(32'h0, 32'h0000_0055, 4'hF, 1'b1, rd, n, rc, ra, rd2);
        checks++; if (n !== 2 || rd !== 32'h0) begin errors++; $display("FAIL instr_fetch: latency %0d rdata 0x%08h, required 2 and 0x00000000", n, rd); end
        bus_xfer(32'h0, 32'h0000_0066, 4'h2, 1'b0, rd, n, rc, ra, rd2);
        checks++; if (n !== 2) begin errors++; $display("FAIL upper_strobe_write: latency %0d, required 2", n); end
        bus_xfer(32'h0, 32'h0000_0077, 4'h0, 1'b0, rd, n, rc, ra, rd2);
        checks++; if (n !== 2 || rd !== 32'h0) begin errors++; $display("FAIL txdata_read: latency %0d rdata 0x%08h, required 2 and 0x00000000", n, rd); end
        bus_xfer(32'h4, 32'h0000_0088, 4'h1, 1'b0, rd, n, rc, ra, rd2);
        checks++; if (n !== 2) begin errors++; $display("FAIL status_write: latency %0d, required 2", n); end
        repeat (60) @(negedge clock);
        checks++; if (frame_count !== fc0) begin errors++; $display("FAIL no_push_frames: got %0d, required %0d", frame_count, fc0); end
        bus_xfer(32'h4, 32'h0, 4'h0, 1'b0, rd, n, rc, ra, rd2);
        checks++; if (rd !== 32'h0000_0002) begin errors++; $display("FAIL no_push_status: got 0x%08h, required 0x00000002", rd); end
    endtask

    task automatic test_reset_mid_frame;
        logic [31:0] rd, rd2;
        int n, rc, fc0;
        logic ra;
        fc0 = frame_count;
        exp_q.push_back(8'hC3);
        exp_q.push_back(8'h3C);
        bus_xfer(32'h0, 32'h0000_00C3, 4'h1, 1'b0, rd, n, rc, ra, rd2);
        bus_xfer(32'h0, 32'h0000_003C, 4'h1, 1'b0, rd, n, rc, ra, rd2);
        for (int i = 0; i < 100 && !(mon_active && mon_k >= 2 * CPB + 2); i++) @(negedge clock);
        checks++; if (!(mon_active && mon_k >= 2 * CPB + 2)) begin errors++; $display("FAIL reach_data_state: decoder active %b, required 1", mon_active); end
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL abort_tx: got %b, required 1", uart_tx); end
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        bus_xfer(32'h4, 32'h0, 4'h0, 1'b0, rd, n, rc, ra, rd2);
        checks++; if (rd !== 32'h0000_0002) begin errors++; $display("FAIL status_post_abort: got 0x%08h, required 0x00000002", rd); end
        repeat (100) @(negedge clock);
        checks++; if (frame_count !== fc0 || uart_tx !== 1'b1) begin errors++; $display("FAIL frames_post_abort: frames %0d tx %b, required %0d and 1", frame_count, uart_tx, fc0); end
    endtask

    initial begin
        reset      = 1'b1;
        uart_valid = 1'b0;
        uart_instr = 1'b0;
        uart_addr  = 32'h0;
        uart_wdata = 32'h0;
        uart_wstrb = 4'h0;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_fill_status();
        test_no_push_cases();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
